hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline hazard and stall controller for the 5-stage RV32I core.
- Sits upstream of the EX-stage forwarding unit. Drives the PC, IF/ID, ID/EX and EX/MEM register enables and flushes.
- Handles three cases: load-use stalls (which forwarding cannot resolve), taken-branch flushes, and multi-cycle MUL/DIV occupancy of EX, with a watchdog on the multi-cycle unit.

Parameters:
- MD_TIMEOUT, 64: max cycles in MD_BUSY before abort; legal range 2..1023.
- CNT_W, 32: width of optional performance counters.

Ports:
- clk  in  1  core clock
- rst  in  1  reset
- if_id_rs1  in  reg_addr_t  rs1 of instruction in ID
- if_id_rs2  in  reg_addr_t  rs2 of instruction in ID
- if_id_uses_rs1  in  1  ID instruction reads rs1
- if_id_uses_rs2  in  1  ID instruction reads rs2
- id_ex_rd  in  reg_addr_t  rd of instruction in EX
- id_ex_mem_read  in  1  EX instruction is a load
- ex_branch_taken  in  1  branch/jump in EX resolved taken
- ex_md_start  in  1  MUL/DIV op present in EX this cycle
- md_done  in  1  MUL/DIV result valid
- pc_en  out  1  PC register enable
- if_id_en  out  1  IF/ID register enable
- if_id_flush  out  1  IF/ID loads NOP
- id_ex_en  out  1  ID/EX register enable
- id_ex_flush  out  1  ID/EX loads bubble
- ex_mem_flush  out  1  EX/MEM loads bubble
- md_abort  out  1  one-cycle pulse on watchdog expiry
- md_timeout_err  out  1  sticky watchdog error
- loaduse_cnt, branch_cnt, md_stall_cnt  out  CNT_W each  performance counters

Behaviour:
- Interface: one clock `clk`. Reset `rst` is synchronous and active-high.
- While rst=1:
  - pc_en, if_id_en and id_ex_en are 0.
  - if_id_flush, id_ex_flush and ex_mem_flush are 1.
  - md_abort=0, md_timeout_err=0, counters=0, state=RUN, timer=0.
- Flops are 2-state FSM {RUN, MD_BUSY} plus a timer of width $clog2(MD_TIMEOUT+1). All other outputs are combinational from state and inputs, so they take effect in the same cycle.
- Defaults (no hazard): all enables 1, all flushes 0.
- RUN, evaluated in priority order:
  1. ex_branch_taken=1 → if_id_flush=1, id_ex_flush=1, pc_en=1 (PC takes target). Overrides load-use.
  2. ex_md_start=1 and md_done=0 → pc_en=0, if_id_en=0, id_ex_en=0, ex_mem_flush=1. Next state MD_BUSY, timer←1.
  3. ex_md_start=1 and md_done=1 → single-cycle result, no stall, stay RUN.
  4. Load-use: id_ex_mem_read=1 and id_ex_rd≠0 and ((if_id_uses_rs1 and id_ex_rd==if_id_rs1) or (if_id_uses_rs2 and id_ex_rd==if_id_rs2)) → pc_en=0, if_id_en=0, id_ex_flush=1 (one bubble; id_ex_en remains 1).
  - A load-use hazard is never evaluated when rd=x0.
- MD_BUSY:
  - md_done=0 and timer<MD_TIMEOUT → same stall outputs as RUN case 2; timer increments.
  - md_done=1 → all enables 1, ex_mem_flush=0 (result captured); next state RUN, timer←0.
  - timer==MD_TIMEOUT and md_done=0 → md_abort=1 for this cycle, ex_mem_flush=1, enables 1, md_timeout_err←1 (sticky until rst); next state RUN.
  - md_done=1 and timer==MD_TIMEOUT in the same cycle → done wins, no abort.
  - ex_branch_taken and load-use inputs are ignored in MD_BUSY.
- Reset asserted mid-MD_BUSY → next cycle RUN, timer 0, err cleared.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined: three saturating counters, cleared by rst; saturate at all-ones, no wrap.
  - loaduse_cnt +1 per load-use stall cycle.
  - branch_cnt +1 per taken-branch flush.
  - md_stall_cnt +1 per cycle with pc_en=0 due to MUL/DIV.
- Undefined: counter ports present and tied to 0; no counter flops.

Decomposition:
- riscv_pkg additions:
  - hazard_state_t enum {HZ_RUN, HZ_MD_BUSY}.
  - HZ_MD_TIMEOUT_DEFAULT constant.
  - Existing reg_addr_t is reused.
- Sub-module sat_counter (parameter W; ports clk, rst, inc, count) holds a single saturating counter. It is instantiated three times under HAZARD_PERF_CNT_EN.

Test Plan:
- Load-use: lw x5 in EX (id_ex_mem_read=1, id_ex_rd=5); ID add uses rs2=5 → one cycle of pc_en=0, if_id_en=0, id_ex_flush=1. Same with id_ex_rd=0 → no stall.
- Branch over load-use: ex_branch_taken=1 with a matching load-use → if_id_flush=1, id_ex_flush=1, pc_en=1; no stall.
- MUL/DIV: ex_md_start=1, md_done asserted 5 cycles later → stall outputs for cycles 0–4, release with ex_mem_flush=0 on cycle 5; FSM back in RUN.
- Watchdog: MD_TIMEOUT=8, md_done never asserted → md_abort pulse at timer=8, md_timeout_err stays 1, FSM RUN; rst clears err.
- Reset mid-MD_BUSY: rst for 1 cycle at timer=3 → enables 0 and flushes 1 during rst; RUN with defaults afterward.
- Perf counters (macro on, CNT_W=4): 20 load-use stalls → loaduse_cnt=15 (saturated).

Source files
------------

// File: rtl/riscv_pkg.sv
// ============================================================================
// Module  : riscv_pkg
// Brief   : Shared RV32I core types plus hazard controller state and defaults.
// Revision: 1.0 - initial hazard controller additions
// ============================================================================
`default_nettype none

package riscv_pkg;

   typedef logic [4:0] reg_addr_t;

   typedef enum logic [0:0] {
      HZ_RUN     = 1'b0,
      HZ_MD_BUSY = 1'b1
   } hazard_state_t;

   localparam int HZ_MD_TIMEOUT_DEFAULT = 64;

   // A load writing x0 never creates a dependency, whatever the ID operands are.
   function automatic logic load_use_match(
      input logic      mem_read,
      input reg_addr_t rd,
      input logic      uses_rs1,
      input reg_addr_t rs1,
      input logic      uses_rs2,
      input reg_addr_t rs2
   );
      return mem_read && (rd != 5'd0) &&
             ((uses_rs1 && (rd == rs1)) || (uses_rs2 && (rd == rs2)));
   endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_ctrl_sat_counter.sv
// ============================================================================
// Module  : sat_counter
// Brief   : Single W-bit up-counter that holds at all-ones instead of wrapping.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] count
);

   localparam logic [W-1:0] c_MAX = '1;

   logic [W-1:0] r_count;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= '0;
      end else if (inc && (r_count != c_MAX)) begin
         r_count <= r_count + W'(1);
      end
   end

   assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// ============================================================================
// Module  : hazard_ctrl
// Brief   : Load-use / branch / MUL-DIV stall and flush control for the 5-stage
//           pipeline. Perf counters are built only when HAZARD_PERF_CNT_EN is
//           defined; otherwise the counter ports read as zero.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_ctrl
   import riscv_pkg::*;
#(
   parameter int MD_TIMEOUT = HZ_MD_TIMEOUT_DEFAULT,
   parameter int CNT_W      = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  reg_addr_t        if_id_rs1,
   input  reg_addr_t        if_id_rs2,
   input  logic             if_id_uses_rs1,
   input  logic             if_id_uses_rs2,
   input  reg_addr_t        id_ex_rd,
   input  logic             id_ex_mem_read,
   input  logic             ex_branch_taken,
   input  logic             ex_md_start,
   input  logic             md_done,
   output logic             pc_en,
   output logic             if_id_en,
   output logic             if_id_flush,
   output logic             id_ex_en,
   output logic             id_ex_flush,
   output logic             ex_mem_flush,
   output logic             md_abort,
   output logic             md_timeout_err,
   output logic [CNT_W-1:0] loaduse_cnt,
   output logic [CNT_W-1:0] branch_cnt,
   output logic [CNT_W-1:0] md_stall_cnt
);

   localparam int                c_TMR_W   = $clog2(MD_TIMEOUT + 1);
   localparam logic [c_TMR_W-1:0] c_TMR_MAX = c_TMR_W'(MD_TIMEOUT);
   localparam logic [c_TMR_W-1:0] c_TMR_ONE = c_TMR_W'(1);

   hazard_state_t      r_state;
   hazard_state_t      w_next_state;
   logic [c_TMR_W-1:0] r_timer;
   logic [c_TMR_W-1:0] w_next_timer;
   logic               r_err;
   logic               w_set_err;
   logic               w_load_use;

   assign w_load_use = load_use_match(id_ex_mem_read, id_ex_rd,
                                      if_id_uses_rs1, if_id_rs1,
                                      if_id_uses_rs2, if_id_rs2);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= HZ_RUN;
         r_timer <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_next_state;
         r_timer <= w_next_timer;
         if (w_set_err) begin
            r_err <= 1'b1;
         end
      end
   end

   always_comb begin
      pc_en        = 1'b1;
      if_id_en     = 1'b1;
      id_ex_en     = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      ex_mem_flush = 1'b0;
      md_abort     = 1'b0;
      w_set_err    = 1'b0;
      w_next_state = r_state;
      w_next_timer = r_timer;

      if (rst) begin
         pc_en        = 1'b0;
         if_id_en     = 1'b0;
         id_ex_en     = 1'b0;
         if_id_flush  = 1'b1;
         id_ex_flush  = 1'b1;
         ex_mem_flush = 1'b1;
         w_next_state = HZ_RUN;
         w_next_timer = '0;
      end else begin
         unique case (r_state)
            HZ_RUN: begin
               if (ex_branch_taken) begin
                  if_id_flush = 1'b1;
                  id_ex_flush = 1'b1;
               end else if (ex_md_start && !md_done) begin
                  pc_en        = 1'b0;
                  if_id_en     = 1'b0;
                  id_ex_en     = 1'b0;
                  ex_mem_flush = 1'b1;
                  w_next_state = HZ_MD_BUSY;
                  w_next_timer = c_TMR_ONE;
               end else if (ex_md_start) begin
                  // Result already valid: the op retires like a plain ALU op.
                  w_next_state = HZ_RUN;
               end else if (w_load_use) begin
                  pc_en       = 1'b0;
                  if_id_en    = 1'b0;
                  id_ex_flush = 1'b1;
               end
            end

            HZ_MD_BUSY: begin
               // Completion is checked first so a late result still beats the watchdog.
               if (md_done) begin
                  w_next_state = HZ_RUN;
                  w_next_timer = '0;
               end else if (r_timer >= c_TMR_MAX) begin
                  md_abort     = 1'b1;
                  ex_mem_flush = 1'b1;
                  w_set_err    = 1'b1;
                  w_next_state = HZ_RUN;
                  w_next_timer = '0;
               end else begin
                  pc_en        = 1'b0;
                  if_id_en     = 1'b0;
                  id_ex_en     = 1'b0;
                  ex_mem_flush = 1'b1;
                  w_next_timer = r_timer + c_TMR_ONE;
               end
            end

            default: begin
               w_next_state = HZ_RUN;
               w_next_timer = '0;
            end
         endcase
      end
   end

   assign md_timeout_err = r_err && !rst;

`ifdef HAZARD_PERF_CNT_EN
   logic w_inc_lu;
   logic w_inc_br;
   logic w_inc_md;

   // pc_en low outside reset is either a load-use bubble or a MUL/DIV stall.
   assign w_inc_lu = !rst && (r_state == HZ_RUN) && !ex_branch_taken &&
                     !ex_md_start && w_load_use;
   assign w_inc_br = !rst && (r_state == HZ_RUN) && ex_branch_taken;
   assign w_inc_md = !rst && !pc_en && !w_inc_lu;

   sat_counter #(.W(CNT_W)) u_loaduse_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (w_inc_lu),
      .count (loaduse_cnt)
   );

   sat_counter #(.W(CNT_W)) u_branch_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (w_inc_br),
      .count (branch_cnt)
   );

   sat_counter #(.W(CNT_W)) u_md_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (w_inc_md),
      .count (md_stall_cnt)
   );
`else
   assign loaduse_cnt  = '0;
   assign branch_cnt   = '0;
   assign md_stall_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
// Module  : tb_hazard_ctrl
// Brief   : Directed self-checking bench for hazard_ctrl (MD_TIMEOUT=8, CNT_W=4);
//           counter expectations follow HAZARD_PERF_CNT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_ctrl;
   import riscv_pkg::*;

   localparam int c_TO = 8;
   localparam int c_CW = 4;

   // {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_flush, md_abort, md_timeout_err}
   localparam logic [7:0] c_RST   = 8'b0010_1100;
   localparam logic [7:0] c_IDLE  = 8'b1101_0000;
   localparam logic [7:0] c_IDLEE = 8'b1101_0001;
   localparam logic [7:0] c_LU    = 8'b0001_1000;
   localparam logic [7:0] c_BR    = 8'b1111_1000;
   localparam logic [7:0] c_MDST  = 8'b0000_0100;
   localparam logic [7:0] c_ABORT = 8'b1101_0110;

`ifdef HAZARD_PERF_CNT_EN
   localparam int c_EXP_LU3 = 3;
   localparam int c_EXP_LU  = 15;
   localparam int c_EXP_BR  = 2;
   localparam int c_EXP_MD  = 2;
`else
   localparam int c_EXP_LU3 = 0;
   localparam int c_EXP_LU  = 0;
   localparam int c_EXP_BR  = 0;
   localparam int c_EXP_MD  = 0;
`endif

   logic            clk = 1'b0;
   logic            rst;
   reg_addr_t       if_id_rs1, if_id_rs2, id_ex_rd;
   logic            if_id_uses_rs1, if_id_uses_rs2, id_ex_mem_read;
   logic            ex_branch_taken, ex_md_start, md_done;
   logic            pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_flush;
   logic            md_abort, md_timeout_err;
   logic [c_CW-1:0] loaduse_cnt, branch_cnt, md_stall_cnt;
   logic [7:0]      w_outs;

   int n_total = 0;
   int n_bad   = 0;

   always #5 clk = ~clk;

   assign w_outs = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
                    ex_mem_flush, md_abort, md_timeout_err};

   hazard_ctrl #(.MD_TIMEOUT(c_TO), .CNT_W(c_CW)) u_dut (
      .clk             (clk),
      .rst             (rst),
      .if_id_rs1       (if_id_rs1),
      .if_id_rs2       (if_id_rs2),
      .if_id_uses_rs1  (if_id_uses_rs1),
      .if_id_uses_rs2  (if_id_uses_rs2),
      .id_ex_rd        (id_ex_rd),
      .id_ex_mem_read  (id_ex_mem_read),
      .ex_branch_taken (ex_branch_taken),
      .ex_md_start     (ex_md_start),
      .md_done         (md_done),
      .pc_en           (pc_en),
      .if_id_en        (if_id_en),
      .if_id_flush     (if_id_flush),
      .id_ex_en        (id_ex_en),
      .id_ex_flush     (id_ex_flush),
      .ex_mem_flush    (ex_mem_flush),
      .md_abort        (md_abort),
      .md_timeout_err  (md_timeout_err),
      .loaduse_cnt     (loaduse_cnt),
      .branch_cnt      (branch_cnt),
      .md_stall_cnt    (md_stall_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      if_id_rs1       = 5'd0;
      if_id_rs2       = 5'd0;
      if_id_uses_rs1  = 1'b0;
      if_id_uses_rs2  = 1'b0;
      id_ex_rd        = 5'd0;
      id_ex_mem_read  = 1'b0;
      ex_branch_taken = 1'b0;
      ex_md_start     = 1'b0;
      md_done         = 1'b0;
   endtask

   // lw x5 in EX, ID instruction reads x5 through rs2
   task automatic set_lu();
      id_ex_mem_read = 1'b1;
      id_ex_rd       = 5'd5;
      if_id_uses_rs2 = 1'b1;
      if_id_rs2      = 5'd5;
   endtask

   initial begin
      idle();
      rst = 1'b1;
      step();
      step();
      chk("reset_outs", w_outs, c_RST);
      chk("reset_lucnt", loaduse_cnt, 0);
      rst = 1'b0;
      #1 chk("idle", w_outs, c_IDLE);

      // load-use variants
      set_lu();
      #1 chk("lu_rs2", w_outs, c_LU);
      step();
      idle();
      id_ex_mem_read = 1'b1; id_ex_rd = 5'd7; if_id_uses_rs1 = 1'b1; if_id_rs1 = 5'd7;
      #1 chk("lu_rs1", w_outs, c_LU);
      id_ex_rd = 5'd0; if_id_rs1 = 5'd0;
      #1 chk("lu_x0", w_outs, c_IDLE);
      idle();
      id_ex_mem_read = 1'b1; id_ex_rd = 5'd5; if_id_rs2 = 5'd5;
      #1 chk("lu_unused_rs2", w_outs, c_IDLE);
      idle();
      id_ex_rd = 5'd5; if_id_uses_rs2 = 1'b1; if_id_rs2 = 5'd5;
      #1 chk("lu_not_load", w_outs, c_IDLE);

      // branch wins over load-use
      idle();
      set_lu();
      ex_branch_taken = 1'b1;
      #1 chk("branch_over_lu", w_outs, c_BR);
      step();
      idle();

      // MUL/DIV done five cycles after start
      ex_md_start = 1'b1;
      #1 chk("md_c0", w_outs, c_MDST);
      for (int i = 1; i <= 4; i++) begin
         step();
         if (i == 2) begin
            set_lu();
            ex_branch_taken = 1'b1;
         end
         #1 chk($sformatf("md_c%0d", i), w_outs, c_MDST);
      end
      step();
      idle();
      ex_md_start = 1'b1;
      md_done     = 1'b1;
      #1 chk("md_release", w_outs, c_IDLE);
      step();
      idle();
      set_lu();
      #1 chk("md_back_run", w_outs, c_LU);
      idle();
      ex_md_start = 1'b1;
      md_done     = 1'b1;
      #1 chk("md_single", w_outs, c_IDLE);
      step();

      // watchdog expiry at timer == MD_TIMEOUT
      idle();
      ex_md_start = 1'b1;
      #1 chk("wd_c0", w_outs, c_MDST);
      for (int i = 1; i < c_TO; i++) begin
         step();
         #1 chk($sformatf("wd_c%0d", i), w_outs, c_MDST);
      end
      step();
      #1 chk("wd_abort", w_outs, c_ABORT);
      step();
      idle();
      #1 chk("wd_err_sticky", w_outs, c_IDLEE);
      step();
      #1 chk("wd_err_hold", w_outs, c_IDLEE);

      // done and timeout coincide: done wins
      ex_md_start = 1'b1;
      #1 chk("dw_c0", w_outs, c_MDST | 8'h01);
      for (int i = 1; i < c_TO; i++) begin
         step();
      end
      #1 chk("dw_c7", w_outs, c_MDST | 8'h01);
      step();
      md_done = 1'b1;
      #1 chk("dw_done_wins", w_outs, c_IDLEE);
      step();
      idle();
      #1 chk("dw_run", w_outs, c_IDLEE);
      rst = 1'b1;
      #1 chk("err_rst", w_outs, c_RST);
      step();
      rst = 1'b0;
      #1 chk("err_cleared", w_outs, c_IDLE);

      // reset in the middle of MD_BUSY at timer=3
      ex_md_start = 1'b1;
      step();
      step();
      step();
      #1 chk("mid_busy", w_outs, c_MDST);
      rst = 1'b1;
      #1 chk("mid_rst", w_outs, c_RST);
      step();
      rst = 1'b0;
      idle();
      #1 chk("mid_after", w_outs, c_IDLE);
      set_lu();
      #1 chk("mid_run_lu", w_outs, c_LU);

      // perf counters
      idle();
      rst = 1'b1;
      step();
      rst = 1'b0;
      #1 chk("cnt_clear", {loaduse_cnt, branch_cnt, md_stall_cnt}, 0);
      set_lu();
      for (int i = 1; i <= 20; i++) begin
         step();
         if (i == 3) chk("lu_cnt3", loaduse_cnt, c_EXP_LU3);
      end
      chk("lu_cnt_sat", loaduse_cnt, c_EXP_LU);
      idle();
      ex_branch_taken = 1'b1;
      step();
      step();
      chk("br_cnt", branch_cnt, c_EXP_BR);
      idle();
      ex_md_start = 1'b1;
      step();
      step();
      md_done = 1'b1;
      step();
      idle();
      #1 chk("md_cnt", md_stall_cnt, c_EXP_MD);
      chk("lu_cnt_hold", loaduse_cnt, c_EXP_LU);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got=running expected=finished");
      $fatal(1);
   end

endmodule

`default_nettype wire
